alu_op_sequencer: RTL and testbench

// Command buffer and issue stage directly upstream of the 4-bit ALU.
// - Accepts ALU commands (opcode, carry-in, two operands) over a valid/ready handshake.
// - Queues them in a FIFO and drives the ALU inputs from registers, one command at a time.
// - Samples the ALU outputs and returns each result, with its flags, on a valid/ready response port.

---
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO plus issue/response stage in front of a 4-bit ALU.
// Commands are queued, issued one at a time through registered ALU drives, and
// each result (with flags) is returned on a valid/ready response port.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_sel,
    input  logic                       cmd_c,
    input  logic [W-1:0]               cmd_x,
    input  logic [W-1:0]               cmd_y,
    output logic [2:0]                 alu_select,
    output logic                       alu_in_c,
    output logic [W-1:0]               alu_in_x,
    output logic [W-1:0]               alu_in_y,
    input  logic [W-1:0]               alu_out_s,
    input  logic                       alu_out_c,
    input  logic                       alu_zero,
    input  logic                       alu_overflow,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2:0]                 rsp_sel,
    output logic [W-1:0]               rsp_s,
    output logic                       rsp_c,
    output logic                       rsp_zero,
    output logic                       rsp_overflow,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;

    // Command storage; pointers wrap naturally because DEPTH is a power of 2.
    logic [2:0]     fifo_sel [DEPTH];
    logic           fifo_c   [DEPTH];
    logic [W-1:0]   fifo_x   [DEPTH];
    logic [W-1:0]   fifo_y   [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           push;
    logic           pop;
    logic           rsp_done;
    logic           fifo_empty;
    logic [2:0]     head_sel;
    logic           head_c;
    logic [W-1:0]   head_x;
    logic [W-1:0]   head_y;
    logic           head_illegal;

    assign fifo_empty   = (fifo_count == '0);
    assign cmd_ready    = (fifo_count != CW'(DEPTH));
    assign push         = cmd_valid & cmd_ready;
    assign rsp_done     = rsp_valid & rsp_ready;
    // The head is popped as soon as the issue stage is free: from IDLE, or from
    // RESP on the same edge that the current response is handed off.
    assign pop          = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_done));
    assign head_sel     = fifo_sel[rd_ptr];
    assign head_c       = fifo_c[rd_ptr];
    assign head_x       = fifo_x[rd_ptr];
    assign head_y       = fifo_y[rd_ptr];
    assign head_illegal = (head_sel > 3'd4);

    // FIFO payload write; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sel[wr_ptr] <= cmd_sel;
            fifo_c[wr_ptr]   <= cmd_c;
            fifo_x[wr_ptr]   <= cmd_x;
            fifo_y[wr_ptr]   <= cmd_y;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue/response FSM with registered ALU drives and response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_select   <= '0;
            alu_in_c     <= 1'b0;
            alu_in_x     <= '0;
            alu_in_y     <= '0;
            rsp_valid    <= 1'b0;
            rsp_sel      <= '0;
            rsp_s        <= '0;
            rsp_c        <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else if (pop) begin
            if (head_illegal) begin
                // Illegal opcodes bypass the ALU and answer immediately with an error.
                rsp_valid    <= 1'b1;
                rsp_sel      <= head_sel;
                rsp_s        <= '0;
                rsp_c        <= 1'b0;
                rsp_zero     <= 1'b0;
                rsp_overflow <= 1'b0;
                rsp_err      <= 1'b1;
                state        <= RESP;
            end else begin
                alu_select <= head_sel;
                alu_in_c   <= head_c;
                alu_in_x   <= head_x;
                alu_in_y   <= head_y;
                rsp_valid  <= 1'b0;
                state      <= EXEC;
            end
        end else begin
            case (state)
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_sel   <= alu_select;
                    rsp_s     <= alu_out_s;
                    rsp_err   <= 1'b0;
                    if (alu_select == 3'd0 || alu_select == 3'd1) begin
                        rsp_c        <= alu_out_c;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                    end else begin
                        // The ALU flags are meaningless for logic ops; derive zero here.
                        rsp_c        <= 1'b0;
                        rsp_zero     <= (alu_out_s == '0);
                        rsp_overflow <= 1'b0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_sel;
    logic       cmd_c;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic [2:0] alu_select;
    logic       alu_in_c;
    logic [3:0] alu_in_x;
    logic [3:0] alu_in_y;
    logic [3:0] alu_out_s;
    logic       alu_out_c;
    logic       alu_zero;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_sel;
    logic [3:0] rsp_s;
    logic       rsp_c;
    logic       rsp_zero;
    logic       rsp_overflow;
    logic       rsp_err;
    logic [2:0] fifo_count;

    int total;
    int bad;

    alu_op_sequencer #(.DEPTH(4), .W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sel      (cmd_sel),
        .cmd_c        (cmd_c),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .alu_select   (alu_select),
        .alu_in_c     (alu_in_c),
        .alu_in_x     (alu_in_x),
        .alu_in_y     (alu_in_y),
        .alu_out_s    (alu_out_s),
        .alu_out_c    (alu_out_c),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_sel      (rsp_sel),
        .rsp_s        (rsp_s),
        .rsp_c        (rsp_c),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in; logic ops drive deliberately wrong flags so only locally derived flags pass.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        alu_out_s    = '0;
        alu_out_c    = 1'b0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_select)
            3'b000: begin
                alu_sum      = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'b0, alu_in_c};
                alu_out_s    = alu_sum[3:0];
                alu_out_c    = alu_sum[4];
                alu_zero     = (alu_sum[3:0] == 4'd0);
                alu_overflow = (alu_in_x[3] == alu_in_y[3]) && (alu_sum[3] != alu_in_x[3]);
            end
            3'b001: begin
                alu_sum      = {1'b0, alu_in_x} + {1'b0, ~alu_in_y} + {4'b0, alu_in_c};
                alu_out_s    = alu_sum[3:0];
                alu_out_c    = alu_sum[4];
                alu_zero     = (alu_sum[3:0] == 4'd0);
                alu_overflow = (alu_in_x[3] != alu_in_y[3]) && (alu_sum[3] != alu_in_x[3]);
            end
            3'b010: begin alu_out_s = ~alu_in_x;          alu_out_c = 1'b1; alu_overflow = 1'b1; end
            3'b011: begin alu_out_s = alu_in_x & alu_in_y; alu_out_c = 1'b1; alu_overflow = 1'b1; end
            3'b100: begin alu_out_s = alu_in_x | alu_in_y; alu_out_c = 1'b1; alu_overflow = 1'b1; end
            default: alu_out_s = 4'd0;
        endcase
    end

    // Offer one command from a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [2:0] s, input logic c, input logic [3:0] x,
                            input logic [3:0] y, output bit ok);
        cmd_sel = s; cmd_c = c; cmd_x = x; cmd_y = y;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advance negedge by negedge until a response is pending, bounded.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_c = 1'b0;
        cmd_x = '0; cmd_y = '0; rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        total++;
        if ({alu_select, alu_in_c, alu_in_x, alu_in_y, rsp_valid, rsp_sel, rsp_s, rsp_c,
             rsp_zero, rsp_overflow, rsp_err, fifo_count} !== 30'd0) begin
            bad++; $display("FAIL reset_outputs: got rsp_valid=%b fifo_count=%0d alu_x=%h want all zero",
                            rsp_valid, fifo_count, alu_in_x);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({cmd_ready, fifo_count, rsp_valid} !== {1'b1, 3'd0, 1'b0}) begin
            bad++; $display("FAIL reset_release: got cmd_ready=%b fifo_count=%0d rsp_valid=%b want 1 0 0",
                            cmd_ready, fifo_count, rsp_valid);
        end
        $display("test_reset: done");
    endtask

    task automatic test_add;
        bit ok;
        rsp_ready = 1'b1;
        send_cmd(3'b000, 1'b0, 4'd3, 4'd4, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL add_accept: got no accept want accept"); end
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_lat_n: got rsp_valid=%b want 0", rsp_valid); end
        @(negedge clk);
        total++;
        if ({rsp_valid, alu_select, alu_in_x, alu_in_y} !== {1'b0, 3'b000, 4'd3, 4'd4}) begin
            bad++; $display("FAIL add_exec: got valid=%b sel=%b x=%h y=%h want 0 000 3 4",
                            rsp_valid, alu_select, alu_in_x, alu_in_y);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !==
            {1'b1, 3'b000, 4'd7, 4'b0000}) begin
            bad++; $display("FAIL add_rsp: got v=%b sel=%b s=%h c=%b z=%b o=%b e=%b want 1 000 7 0 0 0 0",
                            rsp_valid, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_consumed: got rsp_valid=%b want 0", rsp_valid); end
        $display("test_add: 3+4 -> s=%h", rsp_s);
    endtask

    task automatic test_sub_ovf;
        bit ok;
        rsp_ready = 1'b1;
        send_cmd(3'b001, 1'b1, 4'd5, 4'd5, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL sub_zero: got ok=%b s=%h c=%b z=%b o=%b e=%b want s=0 c=1 z=1 o=0 e=0",
                            ok, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        send_cmd(3'b000, 1'b0, 4'd7, 4'd1, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {4'd8, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL add_ovf: got ok=%b s=%h c=%b z=%b o=%b e=%b want s=8 c=0 z=0 o=1 e=0",
                            ok, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        $display("test_sub_ovf: done");
    endtask

    task automatic test_logic;
        bit ok;
        rsp_ready = 1'b1;
        send_cmd(3'b011, 1'b0, 4'b1010, 4'b0101, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {3'b011, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL and_zero: got ok=%b sel=%b s=%h c=%b z=%b o=%b e=%b want 011 0 0 1 0 0",
                            ok, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        send_cmd(3'b010, 1'b0, 4'd0, 4'd0, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {3'b010, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL not_zero: got ok=%b sel=%b s=%h c=%b z=%b o=%b e=%b want 010 f 0 0 0 0",
                            ok, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        $display("test_logic: done");
    endtask

    task automatic test_back_to_back;
        int accepted;
        int got;
        int last;
        logic rdy;
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            cmd_valid = (accepted < 6);
            cmd_sel = 3'b000; cmd_c = 1'b0; cmd_x = 4'(accepted); cmd_y = 4'd1;
            rdy = cmd_ready;
            @(negedge clk);
            if (rdy && cmd_valid) accepted++;
        end
        cmd_valid = 1'b0;
        total++;
        if ({accepted[3:0], cmd_ready, fifo_count, rsp_valid, rsp_s} !== {4'd5, 1'b0, 3'd4, 1'b1, 4'd1}) begin
            bad++; $display("FAIL b2b_full: got acc=%0d cmd_ready=%b count=%0d v=%b s=%h want 5 0 4 1 1",
                            accepted, cmd_ready, fifo_count, rsp_valid, rsp_s);
        end
        rsp_ready = 1'b1;
        got  = 0;
        last = -1;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            if (rsp_valid) begin
                total++;
                if (rsp_s !== 4'(got + 1)) begin
                    bad++; $display("FAIL b2b_order: rsp %0d got s=%h want %h", got, rsp_s, 4'(got + 1));
                end
                if (got > 0) begin
                    total++;
                    if (cyc - last != 2) begin
                        bad++; $display("FAIL b2b_spacing: rsp %0d got gap=%0d want 2", got, cyc - last);
                    end
                end
                $display("test_back_to_back: rsp %0d s=%h", got, rsp_s);
                last = cyc;
                got++;
            end
            @(negedge clk);
        end
        total++;
        if ({got[3:0], rsp_valid, fifo_count} !== {4'd5, 1'b0, 3'd0}) begin
            bad++; $display("FAIL b2b_drain: got n=%0d v=%b count=%0d want 5 0 0", got, rsp_valid, fifo_count);
        end
    endtask

    task automatic test_illegal;
        bit ok;
        rsp_ready = 1'b1;
        send_cmd(3'b110, 1'b0, 4'd9, 4'd9, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {3'b110, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL illegal_rsp: got ok=%b sel=%b s=%h c=%b z=%b o=%b e=%b want 110 0 0 0 0 1",
                            ok, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        total++;
        if ({alu_select, alu_in_c, alu_in_x, alu_in_y} !== {3'b000, 1'b0, 4'd4, 4'd1}) begin
            bad++; $display("FAIL illegal_alu_hold: got sel=%b c=%b x=%h y=%h want 000 0 4 1",
                            alu_select, alu_in_c, alu_in_x, alu_in_y);
        end
        @(negedge clk);
        send_cmd(3'b100, 1'b1, 4'b1001, 4'b0110, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {3'b100, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL illegal_next: got ok=%b sel=%b s=%h c=%b z=%b o=%b e=%b want 100 f 0 0 0 0",
                            ok, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        $display("test_illegal: done");
    endtask

    task automatic test_reset_mid;
        int accepted;
        logic rdy;
        bit ok;
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_valid = (accepted < 5);
            cmd_sel = 3'b000; cmd_c = 1'b0; cmd_x = 4'(accepted); cmd_y = 4'd0;
            rdy = cmd_ready;
            @(negedge clk);
            if (rdy && cmd_valid) accepted++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({fifo_count, rsp_valid} !== {3'd3, 1'b0}) begin
            bad++; $display("FAIL mid_exec: got count=%0d v=%b want 3 0", fifo_count, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({alu_select, alu_in_c, alu_in_x, alu_in_y, rsp_valid, rsp_sel, rsp_s, rsp_c,
             rsp_zero, rsp_overflow, rsp_err, fifo_count} !== 30'd0) begin
            bad++; $display("FAIL mid_reset: got v=%b count=%0d alu_x=%h rsp_s=%h want all zero",
                            rsp_valid, fifo_count, alu_in_x, rsp_s);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_cmd(3'b000, 1'b1, 4'd2, 4'd5, ok);
        wait_rsp(ok);
        total++;
        if (!ok || {rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err} !== {3'b000, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL mid_after: got ok=%b sel=%b s=%h c=%b z=%b o=%b e=%b want 000 8 0 0 1 0",
                            ok, rsp_sel, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, fifo_count} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL mid_idle: got v=%b count=%0d want 0 0", rsp_valid, fifo_count);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub_ovf();
        test_logic();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
